// File: rtl/rx_client_if.sv
// Receive client interface: two-stage data pipeline with SOF/EOF marking, frame length and
// CRC-status resolution. Define RX_STATS_EN to build the good/bad/byte statistics counters.
module rx_client_if #(
  parameter int          TP             = 1,
  parameter int unsigned MAX_LEN        = 1518,
  parameter int unsigned STATUS_TIMEOUT = 16
) (
  input  logic        rxclk,
  input  logic        reset,
  input  logic [63:0] rx_data,
  input  logic [7:0]  rx_data_valid,
  input  logic        crc_ok,
  input  logic        crc_err,
  output logic [63:0] client_data,
  output logic [7:0]  client_valid,
  output logic        client_sof,
  output logic        client_eof,
  output logic        client_good_frame,
  output logic        client_bad_frame,
  output logic [15:0] frame_len,
  output logic [31:0] stat_frames_ok,
  output logic [31:0] stat_frames_bad,
  output logic [31:0] stat_bytes
);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] DATA        = 2'd1;
  localparam logic [1:0] WAIT_STATUS = 2'd2;

  localparam int unsigned TmoW = $clog2(STATUS_TIMEOUT + 2);

  // TP is kept for instantiation compatibility only; no delay is modelled in this RTL.
  if (TP < 0) begin : g_tp_invalid
    $error("rx_client_if: TP must be non-negative");
  end

  logic [1:0]      r_state, w_state;
  logic [15:0]     r_len, w_len;
  logic            r_nc, w_nc;
  logic [TmoW-1:0] r_tmo, w_tmo;
  logic            r_got_ok, w_got_ok;
  logic            r_got_err, w_got_err;

  logic [63:0] r_hold_data;
  logic [7:0]  r_hold_valid;
  logic        r_hold_sof, r_hold_eof;

  logic [63:0] r_client_data;
  logic [7:0]  r_client_valid;
  logic        r_client_sof, r_client_eof;
  logic        r_good, r_bad;
  logic [15:0] r_frame_len;

  logic        w_sof, w_eof, w_force_eof, w_good, w_bad, w_start;
  logic [3:0]  w_cnt;
  logic        w_contig;
  logic [16:0] w_sum;
  logic [15:0] w_len_acc;
  logic        w_ok, w_err, w_len_bad;

  always_comb begin
    w_cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_cnt = w_cnt + {3'b000, rx_data_valid[i]};
    end
  end

  // A legal mask is a run of ones from bit 0, so adding one clears every set bit.
  assign w_contig  = ((rx_data_valid & (rx_data_valid + 8'd1)) == 8'd0);
  assign w_sum     = {1'b0, r_len} + {13'd0, w_cnt};
  assign w_len_acc = w_sum[16] ? 16'hFFFF : w_sum[15:0];
  assign w_ok      = r_got_ok | crc_ok;
  assign w_err     = r_got_err | crc_err;
  assign w_len_bad = ({16'd0, r_len} > MAX_LEN) || (r_len < 16'd64);

  always_comb begin
    w_state     = r_state;
    w_len       = r_len;
    w_nc        = r_nc;
    w_tmo       = r_tmo;
    w_got_ok    = r_got_ok;
    w_got_err   = r_got_err;
    w_sof       = 1'b0;
    w_eof       = 1'b0;
    w_force_eof = 1'b0;
    w_good      = 1'b0;
    w_bad       = 1'b0;
    w_start     = 1'b0;

    case (r_state)
      IDLE: begin
        if (rx_data_valid != 8'h00) w_start = 1'b1;
      end
      DATA: begin
        if (rx_data_valid == 8'hFF) begin
          w_len = w_len_acc;
        end else if (rx_data_valid == 8'h00) begin
          // The held word becomes the last word; it reaches the output one cycle sooner,
          // so the timeout count starts one ahead.
          w_force_eof = 1'b1;
          w_state     = WAIT_STATUS;
          w_tmo       = TmoW'(1);
          w_got_ok    = crc_ok;
          w_got_err   = crc_err;
        end else begin
          w_eof     = 1'b1;
          w_len     = w_len_acc;
          w_nc      = r_nc | ~w_contig;
          w_state   = WAIT_STATUS;
          w_tmo     = '0;
          w_got_ok  = crc_ok;
          w_got_err = crc_err;
        end
      end
      WAIT_STATUS: begin
        if (rx_data_valid != 8'h00) begin
          w_bad   = 1'b1;
          w_start = 1'b1;
        end else if (w_ok || w_err) begin
          w_state = IDLE;
          if (w_ok && !w_err && !w_len_bad && !r_nc) w_good = 1'b1;
          else                                       w_bad  = 1'b1;
        end else if (r_tmo >= TmoW'(STATUS_TIMEOUT)) begin
          w_state = IDLE;
          w_bad   = 1'b1;
        end else begin
          w_tmo = r_tmo + TmoW'(1);
        end
      end
      default: w_state = IDLE;
    endcase

    if (w_start) begin
      w_sof = 1'b1;
      w_len = {12'd0, w_cnt};
      w_nc  = ~w_contig;
      if (rx_data_valid == 8'hFF) begin
        w_state = DATA;
      end else begin
        w_eof     = 1'b1;
        w_state   = WAIT_STATUS;
        w_tmo     = '0;
        w_got_ok  = crc_ok;
        w_got_err = crc_err;
      end
    end
  end

  always_ff @(posedge rxclk) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_len          <= '0;
      r_nc           <= 1'b0;
      r_tmo          <= '0;
      r_got_ok       <= 1'b0;
      r_got_err      <= 1'b0;
      r_hold_data    <= '0;
      r_hold_valid   <= '0;
      r_hold_sof     <= 1'b0;
      r_hold_eof     <= 1'b0;
      r_client_data  <= '0;
      r_client_valid <= '0;
      r_client_sof   <= 1'b0;
      r_client_eof   <= 1'b0;
      r_good         <= 1'b0;
      r_bad          <= 1'b0;
      r_frame_len    <= '0;
    end else begin
      r_state        <= w_state;
      r_len          <= w_len;
      r_nc           <= w_nc;
      r_tmo          <= w_tmo;
      r_got_ok       <= w_got_ok;
      r_got_err      <= w_got_err;
      r_hold_data    <= rx_data;
      r_hold_valid   <= rx_data_valid;
      r_hold_sof     <= w_sof;
      r_hold_eof     <= w_eof;
      r_client_data  <= r_hold_data;
      r_client_valid <= r_hold_valid;
      r_client_sof   <= r_hold_sof;
      r_client_eof   <= r_hold_eof | w_force_eof;
      r_good         <= w_good;
      r_bad          <= w_bad;
      if (r_hold_eof || w_force_eof) r_frame_len <= r_len;
    end
  end

  assign client_data       = r_client_data;
  assign client_valid      = r_client_valid;
  assign client_sof        = r_client_sof;
  assign client_eof        = r_client_eof;
  assign client_good_frame = r_good;
  assign client_bad_frame  = r_bad;
  assign frame_len         = r_frame_len;

`ifdef RX_STATS_EN
  logic [31:0] r_stat_ok, r_stat_bad, r_stat_bytes;

  always_ff @(posedge rxclk) begin
    if (!reset) begin
      r_stat_ok    <= '0;
      r_stat_bad   <= '0;
      r_stat_bytes <= '0;
    end else begin
      if (w_good) begin
        r_stat_ok    <= r_stat_ok + 32'd1;
        r_stat_bytes <= r_stat_bytes + {16'd0, r_len};
      end
      if (w_bad) r_stat_bad <= r_stat_bad + 32'd1;
    end
  end

  assign stat_frames_ok  = r_stat_ok;
  assign stat_frames_bad = r_stat_bad;
  assign stat_bytes      = r_stat_bytes;
`else
  assign stat_frames_ok  = '0;
  assign stat_frames_bad = '0;
  assign stat_bytes      = '0;
`endif

endmodule

// File: tb/tb_rx_client_if.sv
// Directed bench for rx_client_if: expected output words and frame verdicts are queued as
// stimulus is driven and checked as the DUT emits them.
module tb_rx_client_if;

  logic        rxclk = 1'b0;
  logic        reset;
  logic [63:0] rx_data;
  logic [7:0]  rx_data_valid;
  logic        crc_ok, crc_err;
  logic [63:0] client_data;
  logic [7:0]  client_valid;
  logic        client_sof, client_eof, client_good_frame, client_bad_frame;
  logic [15:0] frame_len;
  logic [31:0] stat_frames_ok, stat_frames_bad, stat_bytes;

  always #5 rxclk = ~rxclk;

  rx_client_if dut (
    .rxclk             (rxclk),
    .reset             (reset),
    .rx_data           (rx_data),
    .rx_data_valid     (rx_data_valid),
    .crc_ok            (crc_ok),
    .crc_err           (crc_err),
    .client_data       (client_data),
    .client_valid      (client_valid),
    .client_sof        (client_sof),
    .client_eof        (client_eof),
    .client_good_frame (client_good_frame),
    .client_bad_frame  (client_bad_frame),
    .frame_len         (frame_len),
    .stat_frames_ok    (stat_frames_ok),
    .stat_frames_bad   (stat_frames_bad),
    .stat_bytes        (stat_bytes)
  );

  typedef struct {
    logic [63:0] d;
    logic [7:0]  v;
    logic        sof;
    logic        eof;
    logic [15:0] len;
  } exp_t;

  exp_t        q[$];
  logic [16:0] pq[$];  // {bad, length}
  int n_cmp = 0, n_bad = 0, ncyc = 0, last_eof = 0, last_pulse = 0;
  logic        m_in;
  logic [15:0] m_len;
  logic [31:0] m_ok, m_badc, m_bytes;

  function automatic logic [3:0] popc(input logic [7:0] m);
    logic [3:0] c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, m[i]};
    return c;
  endfunction

  function automatic logic [95:0] exp_stats();
`ifdef RX_STATS_EN
    return {m_ok, m_badc, m_bytes};
`else
    return 96'd0;
`endif
  endfunction

  task automatic chk_val(input string tag, input int got, input int want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic check_cycle();
    exp_t        e;
    logic [16:0] p;
    e = q.pop_front();
    n_cmp++;
    assert ({client_data, client_valid, client_sof, client_eof} === {e.d, e.v, e.sof, e.eof})
    else begin
      n_bad++;
      $error("FAIL word@%0d: got %h/%h sof%b eof%b want %h/%h sof%b eof%b", ncyc, client_data,
             client_valid, client_sof, client_eof, e.d, e.v, e.sof, e.eof);
    end
    if (e.eof) begin
      last_eof = ncyc;
      chk_val("frame_len_at_eof", int'(frame_len), int'(e.len));
    end
    if (client_good_frame || client_bad_frame) begin
      last_pulse = ncyc;
      n_cmp++;
      assert (pq.size() != 0) else begin
        n_bad++;
        $error("FAIL pulse@%0d: got good=%b bad=%b want none", ncyc, client_good_frame,
               client_bad_frame);
      end
      if (pq.size() != 0) begin
        p = pq.pop_front();
        n_cmp++;
        assert ({client_good_frame, client_bad_frame} === {~p[16], p[16]}) else begin
          n_bad++;
          $error("FAIL verdict@%0d: got good=%b bad=%b want good=%b bad=%b", ncyc,
                 client_good_frame, client_bad_frame, ~p[16], p[16]);
        end
        if (p[16]) m_badc++;
        else begin
          m_ok++;
          m_bytes += {16'd0, p[15:0]};
        end
      end
    end
    n_cmp++;
    assert ({stat_frames_ok, stat_frames_bad, stat_bytes} === exp_stats()) else begin
      n_bad++;
      $error("FAIL stats@%0d: got %h want %h", ncyc,
             {stat_frames_ok, stat_frames_bad, stat_bytes}, exp_stats());
    end
  endtask

  task automatic step(input logic [7:0] m, input logic ok, input logic err);
    exp_t e, t;
    e.d = {$urandom(), $urandom()};
    e.v = m; e.sof = 1'b0; e.eof = 1'b0; e.len = '0;
    if (!m_in) begin
      if (m != 8'h00) begin
        e.sof = 1'b1;
        m_len = {12'd0, popc(m)};
        if (m == 8'hFF) m_in = 1'b1;
        else begin
          e.eof = 1'b1;
          e.len = m_len;
        end
      end
    end else if (m == 8'hFF) begin
      m_len += 16'd8;
    end else if (m == 8'h00) begin
      t = q.pop_back();
      t.eof = 1'b1;
      t.len = m_len;
      q.push_back(t);
      m_in = 1'b0;
    end else begin
      m_len += {12'd0, popc(m)};
      e.eof = 1'b1;
      e.len = m_len;
      m_in  = 1'b0;
    end
    rx_data = e.d; rx_data_valid = m; crc_ok = ok; crc_err = err;
    q.push_back(e);
    @(posedge rxclk);
    #1;
    ncyc++;
    check_cycle();
  endtask

  task automatic ff(input int n);
    repeat (n) step(8'hFF, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n, input logic [7:0] m);
    exp_t z;
    reset = 1'b0; rx_data = '1; rx_data_valid = m; crc_ok = 1'b0; crc_err = 1'b0;
    repeat (n) @(posedge rxclk);
    #1;
    n_cmp++;
    assert ({client_data, client_valid, client_sof, client_eof, client_good_frame,
             client_bad_frame, frame_len, stat_frames_ok, stat_frames_bad, stat_bytes} === '0)
    else begin
      n_bad++;
      $error("FAIL reset_state: got data=%h valid=%h sof%b eof%b g%b b%b len=%0d st=%h/%h/%h want 0",
             client_data, client_valid, client_sof, client_eof, client_good_frame,
             client_bad_frame, frame_len, stat_frames_ok, stat_frames_bad, stat_bytes);
    end
    reset = 1'b1;
    z.d = '0; z.v = '0; z.sof = 1'b0; z.eof = 1'b0; z.len = '0;
    q.delete();
    q.push_back(z);
    m_in = 1'b0; m_len = '0; m_ok = '0; m_badc = '0; m_bytes = '0;
  endtask

  initial begin
    do_reset(2, 8'h00);

    // 68-byte frame, status three cycles after the last word
    ff(8); pq.push_back({1'b0, 16'd68}); step(8'h0F, 1'b0, 1'b0);
    idle(2); step(8'h00, 1'b1, 1'b0); idle(3);
    chk_val("len_68", int'(frame_len), 68);

    // empty-mask end with CRC error
    ff(8); pq.push_back({1'b1, 16'd64}); step(8'h00, 1'b0, 1'b1); idle(3);
    chk_val("len_64_err", int'(frame_len), 64);

    // runt single word
    pq.push_back({1'b1, 16'd3}); step(8'h07, 1'b1, 1'b0); idle(3);
    chk_val("len_runt", int'(frame_len), 3);

    // oversize
    ff(190); pq.push_back({1'b1, 16'd1527}); step(8'h7F, 1'b1, 1'b0); idle(3);
    chk_val("len_1527", int'(frame_len), 1527);

    // non-contiguous mask
    ff(8); pq.push_back({1'b1, 16'd66}); step(8'h05, 1'b0, 1'b0);
    step(8'h00, 1'b1, 1'b0); idle(3);
    chk_val("len_noncontig", int'(frame_len), 66);

    // status timeout
    ff(8); pq.push_back({1'b1, 16'd68}); step(8'h0F, 1'b0, 1'b0); idle(20);
    chk_val("timeout_distance", last_pulse - last_eof, 16);

    // both CRC pulses together
    ff(8); pq.push_back({1'b1, 16'd70}); step(8'h3F, 1'b1, 1'b1); idle(3);

    // minimum good length; CRC error mid-frame must be ignored
    ff(4); step(8'hFF, 1'b0, 1'b1); ff(3);
    pq.push_back({1'b0, 16'd64}); step(8'h00, 1'b1, 1'b0); idle(3);
    chk_val("len_min_good", int'(frame_len), 64);

    // maximum good length; CRC error in IDLE must be ignored
    step(8'h00, 1'b0, 1'b1);
    ff(189); pq.push_back({1'b0, 16'd1518}); step(8'h3F, 1'b1, 1'b0); idle(3);
    chk_val("len_max_good", int'(frame_len), 1518);

    // new frame while status pending
    ff(8); pq.push_back({1'b1, 16'd68}); step(8'h0F, 1'b0, 1'b0);
    ff(8); pq.push_back({1'b0, 16'd68}); step(8'h0F, 1'b1, 1'b0); idle(3);

    // reset mid-frame, then a normal frame
    ff(4); do_reset(1, 8'hFF);
    ff(8); pq.push_back({1'b0, 16'd68}); step(8'h0F, 1'b1, 1'b0); idle(3);
    chk_val("len_after_reset", int'(frame_len), 68);

    idle(10);
    chk_val("verdicts_outstanding", pq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rx_client_if.md
RX_CLIENT_IF -- requirements
Module: rx_client_if

Interface
REQ-001 SHALL have parameter TP, default 1, clock-to-output delay applied to all register assignments.
REQ-002 SHALL have parameter MAX_LEN, default 1518, largest good frame length in bytes.
REQ-003 SHALL have parameter STATUS_TIMEOUT, default 16, cycles to wait for CRC status after EOF.
REQ-004 SHALL have ports:
- rxclk  in  1  receive clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- rx_data  in  64  FIFO read data; byte 0 = bits 7:0.
- rx_data_valid  in  8  byte-valid mask, bit n qualifies byte n.
- crc_ok  in  1  one-cycle pulse: current frame CRC good.
- crc_err  in  1  one-cycle pulse: current frame CRC bad.
- client_data  out  64  delayed rx_data.
- client_valid  out  8  delayed rx_data_valid.
- client_sof  out  1  first word of frame.
- client_eof  out  1  last word of frame.
- client_good_frame  out  1  one-cycle pulse, frame accepted.
- client_bad_frame  out  1  one-cycle pulse, frame rejected.
- frame_len  out  16  byte count of last completed frame, held until next EOF.
- stat_frames_ok, stat_frames_bad, stat_bytes  out  32 each  statistics counters.

Function
REQ-005 SHALL register input words into a one-word hold stage; client_* data outputs SHALL lag rx_data by exactly 2 cycles.
REQ-006 SHALL implement FSM states IDLE, DATA, WAIT_STATUS.
REQ-007 IDLE: nonzero mask SHALL mark that word client_sof; if mask != 8'hFF the same word SHALL also carry client_eof and go to WAIT_STATUS, else go to DATA.
REQ-008 DATA: mask 8'hFF SHALL stay; partial nonzero mask SHALL mark that word client_eof and go to WAIT_STATUS; mask 0 SHALL mark the held (previous) word client_eof and go to WAIT_STATUS.
REQ-009 Legal masks SHALL be contiguous from bit 0 (8'h01,8'h03,...,8'hFF); byte count per word = number of set bits; a non-contiguous mask SHALL flag the frame bad.
REQ-010 Running length SHALL sum byte counts and saturate at 16'hFFFF; frame_len SHALL update in the cycle client_eof is asserted.
REQ-011 WAIT_STATUS: crc_ok alone SHALL give good; crc_err, both pulses in the same cycle, length > MAX_LEN, length < 64, or a non-contiguous mask SHALL give bad; then go to IDLE.
REQ-012 crc_ok/crc_err SHALL be accepted from the EOF input cycle onward.
REQ-013 No status within STATUS_TIMEOUT cycles of EOF SHALL give bad and return to IDLE.
REQ-014 A nonzero mask in WAIT_STATUS SHALL resolve the pending frame as bad in that cycle and start a new frame with SOF.
REQ-015 client_good_frame / client_bad_frame SHALL be mutually exclusive, one pulse per frame, no earlier than the client_eof cycle.
REQ-016 CRC pulses in IDLE or DATA SHALL be ignored.

Reset
REQ-017 reset low at a rising edge SHALL force IDLE, and set all outputs, the hold stage, frame_len, the length and timeout counters and the statistics to 0.
REQ-018 A frame in progress at reset SHALL be discarded with no EOF or status pulse; the first nonzero mask after release SHALL be SOF.

Configuration
REQ-019 With RX_STATS_EN defined: stat_frames_ok increments per good pulse; stat_frames_bad per bad pulse; stat_bytes adds frame_len per good frame; all wrap modulo 2^32.
REQ-020 Without RX_STATS_EN: stat_* SHALL be constant 0 and no counter logic SHALL be generated; other behaviour is unchanged.

Verification
REQ-021 Masks FF x8 then 0F, crc_ok 3 cycles later -> SOF on word1, EOF on word9, frame_len=68, one good pulse, stat_bytes=68.
REQ-022 Masks FF x8 then 00, crc_err -> EOF on word8, frame_len=64, one bad pulse, stat_frames_bad=1.
REQ-023 Single word mask 07 with crc_ok -> SOF and EOF on the same word, frame_len=3, bad pulse (runt).
REQ-024 Masks FF x190 then 7F (1527 bytes), crc_ok -> frame_len=1527, bad pulse.
REQ-025 Mask 8'h05 mid-frame -> bad pulse; EOF with no CRC pulse -> bad pulse exactly 16 cycles after EOF; crc_ok and crc_err together -> bad pulse.
REQ-026 reset low during DATA for 1 cycle -> all outputs 0 next cycle, no EOF or status pulse, next frame counted normally.
